// File: rtl/gpio_bus_arb_pkg.sv
// rtl/gpio_bus_arb_pkg.sv - shared encodings and types for the GPIO bus arbiter
package gpio_bus_arb_pkg;

    localparam int NUM_PORTS = 16;
    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              rw;
        logic [DATA_W-1:0] wdata;
    } xfer_t;

    // A write is blocked when the granted requester's mask bit for the port is clear.
    function automatic logic wr_blocked(input logic rw,
                                        input logic [NUM_PORTS-1:0] mask,
                                        input logic [ADDR_W-1:0] addr);
        return !rw && !mask[addr];
    endfunction

endpackage

// File: rtl/gpio_addr_dec.sv
// rtl/gpio_addr_dec.sv - 4-to-16 one-hot port decoder with enable
module gpio_addr_dec
    import gpio_bus_arb_pkg::*;
(
    input  logic                 en,
    input  logic [ADDR_W-1:0]    addr,
    output logic [NUM_PORTS-1:0] sel
);

    always_comb begin
        sel = '0;
        if (en) begin
            sel[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/gpio_bus_arb.sv
// rtl/gpio_bus_arb.sv - two-requester round-robin arbiter onto a GPIO register bank
module gpio_bus_arb
    import gpio_bus_arb_pkg::*;
#(
    parameter logic [NUM_PORTS-1:0] WR_MASK0 = 16'hFFFF,
    parameter logic [NUM_PORTS-1:0] WR_MASK1 = 16'hFFFF
) (
    input  logic                 SYSCLK,
    input  logic                 RESET_N,
    input  logic                 REQ0,
    input  logic                 REQ1,
    input  logic [ADDR_W-1:0]    ADDR0,
    input  logic [ADDR_W-1:0]    ADDR1,
    input  logic                 RW0,
    input  logic                 RW1,
    input  logic [DATA_W-1:0]    WDATA0,
    input  logic [DATA_W-1:0]    WDATA1,
    output logic                 ACK0,
    output logic                 ACK1,
    output logic                 ERR0,
    output logic                 ERR1,
    output logic [DATA_W-1:0]    RDATA0,
    output logic [DATA_W-1:0]    RDATA1,
    output logic                 PORT_CS,
    output logic [NUM_PORTS-1:0] OFFSET_SEL,
    output logic                 RD_WR,
    output logic [DATA_W-1:0]    DIN,
    input  logic [DATA_W-1:0]    DOUT,
    output logic                 BUSY
);

    logic [1:0] state;
    logic       gnt;
    logic       last_gnt;
    xfer_t      xfer;
    logic       elig0;
    logic       elig1;
    logic       pick1;
    logic       blocked;
    logic       in_done;

    assign elig0 = REQ0 && !ACK0;
    assign elig1 = REQ1 && !ACK1;
    // Requester 1 wins alone, or on a tie when requester 0 was served last.
    assign pick1 = elig1 && (!elig0 || !last_gnt);

    assign blocked = wr_blocked(xfer.rw, gnt ? WR_MASK1 : WR_MASK0, xfer.addr);
    assign in_done = (state == ST_DONE);

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= ST_IDLE;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            xfer     <= '0;
            RDATA0   <= '0;
            RDATA1   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (elig0 || elig1) begin
                        gnt   <= pick1;
                        xfer  <= pick1 ? '{addr: ADDR1, rw: RW1, wdata: WDATA1}
                                       : '{addr: ADDR0, rw: RW0, wdata: WDATA0};
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (xfer.rw) begin
                        if (gnt) begin
                            RDATA1 <= DOUT;
                        end else begin
                            RDATA0 <= DOUT;
                        end
                    end
                    state <= ST_DONE;
                end
                default: begin
                    last_gnt <= gnt;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign PORT_CS = (state == ST_ISSUE) && !blocked;
    assign RD_WR   = (state == ST_ISSUE) ? xfer.rw : 1'b1;
    assign DIN     = xfer.wdata;
    assign ACK0    = in_done && !gnt;
    assign ACK1    = in_done && gnt;
    assign ERR0    = ACK0 && blocked;
    assign ERR1    = ACK1 && blocked;
    assign BUSY    = (state != ST_IDLE);

    gpio_addr_dec u_addr_dec (
        .en   (PORT_CS),
        .addr (xfer.addr),
        .sel  (OFFSET_SEL)
    );

endmodule
